htif_mem_bridge: RTL and testbench
==================================

// Module: htif_mem_bridge
// PURPOSE
//  Host-side initiator for the byte-addressed scratchpad's HTIF port (hw_*/hr_*).
//  Parses a 32-bit command word stream from the host, issues masked word writes and
//  asynchronous reads at consecutive addresses, and returns read data plus a status word.
//  Used by the test harness to load programs and dump memory through one valid/ready link.
// PARAMETERS
//  ADDR_WIDTH  21  byte-address width of the memory port (wraps modulo 2^ADDR_WIDTH)
//  DATA_WIDTH  32  data width of stream and memory port; only 32 or 64 allowed
//  (MASK_W = DATA_WIDTH/8 and STEP = DATA_WIDTH/8 are derived)
// PORTS
//  clk        in   1           clock; all state changes on posedge
//  reset      in   1           asynchronous, active-high reset
//  in_valid   in   1           host command/data word valid
//  in_ready   out  1           bridge accepts in_bits this cycle
//  in_bits    in   DATA_WIDTH  header / address / write-data word
//  out_valid  out  1           response word valid (registered)
//  out_ready  in   1           host accepts out_bits
//  out_bits   out  DATA_WIDTH  read data or status word (registered)
//  hw_addr    out  ADDR_WIDTH  memory write byte address
//  hw_data    out  DATA_WIDTH  memory write data
//  hw_mask    out  MASK_W      memory byte-lane write enables
//  hw_en      out  1           memory write strobe (takes effect at posedge)
//  hr_addr    out  ADDR_WIDTH  memory read byte address (combinational read)
//  hr_data    in   DATA_WIDTH  memory read data
//  busy       out  1           high whenever state != IDLE
// BEHAVIOUR
//  Header: [1:0] cmd (1=WRITE, 2=READ, 0/3=reserved), [15:8] byte mask (low MASK_W bits),
//   [23:16] len (words, 0..255), other bits ignored. Next word: byte addr (low ADDR_WIDTH).
//  Status word: {err, 7'b0, header[23:0]}, upper bits above 31 zero. err=1 if cmd
//   reserved or addr not STEP-aligned.
//  FSM: IDLE -> ADDR -> (WDATA | RDATA) -> RESP -> IDLE. Reserved cmd: ADDR -> RESP.
//  IDLE/ADDR/WDATA: in_ready=1; header/addr latched on in_valid&&in_ready.
//  WDATA: hw_en = in_valid && !err (combinational), hw_addr=cur_addr, hw_data=in_bits,
//   hw_mask=hdr mask; each accepted word: cur_addr += STEP, remaining -= 1.
//   With err set, len data words are still consumed but never written.
//  len==0 (either cmd): skip data phase, go straight to RESP.
//  RDATA: in_ready=0; hr_addr=cur_addr; when output register empty or draining
//   (!out_valid || out_ready) load out_bits<=hr_data, out_valid<=1, advance address.
//   First data word valid 1 cycle after entering RDATA; full throughput 1 word/cycle.
//   out_bits holds stable while out_valid && !out_ready. Read error: no data, RESP only.
//  RESP: load status into output register under same rule; return to IDLE when loaded.
//   New header may be accepted in IDLE while status still pending in output register.
//  Address increment wraps modulo 2^ADDR_WIDTH; hw_en/hr_addr never exceed range.
//  hw_en is 0 in every state except WDATA; hr_addr = cur_addr always.
//  Reset (any time, incl. mid-burst): state=IDLE, out_valid=0, out_bits=0, hw_en=0,
//   cur_addr=0, remaining=0, busy=0, in_ready=1 after deassertion; words
//   already written stay written; no status is emitted for the aborted command.
// TESTING
//  1 WRITE hdr 0x00020F01, addr 0x100, data 0xDEADBEEF,0x12345678 -> hw_en at 0x100 then
//    0x104 with mask 0xF; then status 0x00020F01.
//  2 READ hdr 0x00030002, addr 0x100 (after test 1), out_ready toggled 1/0 -> out 0xDEADBEEF,
//    0x12345678, mem[0x108], then 0x00030002; out_bits stable during stalls.
//  3 WRITE hdr 0x00010F01, addr 0x102, data 0xAAAA5555 -> no hw_en, word consumed,
//    status 0x80010F01.
//  4 Reserved hdr 0x00050003, addr 0 -> no data consumed, status 0x80050003; READ/WRITE
//    len=0 -> status only, no hw_en, no data words.
//  5 READ len=2 at 0x1FFFFC -> reads 0x1FFFFC then 0x000000 (wrap); WRITE mask 0x3
//    -> hw_mask 0x3, only low bytes change.
//  6 Assert reset after 1 of 3 write words -> hw_en/out_valid low immediately, IDLE;
//    next full WRITE completes normally with correct status.

Source files
------------

// File: rtl/htif_mem_bridge.sv
// htif_mem_bridge
//   Host-side initiator for the scratchpad's HTIF port. A 32-bit command word
//   stream arrives on in_*. Each command has two parts: a header word and then a
//   byte-address word. The bridge then performs one of two actions:
//     - masked word writes at consecutive addresses, with data taken from in_bits;
//     - asynchronous reads at consecutive addresses, with data returned on out_*.
//   Every command finishes with a status word {err, 7'b0, header[23:0]} on out_*.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   in_valid/in_ready     host command/data stream (in_bits: header/addr/data)
//   out_valid/out_ready   registered response stream (out_bits: read data/status)
//   hw_addr/hw_data/
//   hw_mask/hw_en         memory write port (write takes effect at posedge)
//   hr_addr/hr_data       memory read port (combinational read)
//   busy                  high whenever the FSM is not idle
//
// DATA_WIDTH must be 32 or 64, and ADDR_WIDTH must not exceed DATA_WIDTH.
module htif_mem_bridge #(
    parameter int ADDR_WIDTH = 21,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_bits,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_bits,
    output logic [ADDR_WIDTH-1:0]   hw_addr,
    output logic [DATA_WIDTH-1:0]   hw_data,
    output logic [DATA_WIDTH/8-1:0] hw_mask,
    output logic                    hw_en,
    output logic [ADDR_WIDTH-1:0]   hr_addr,
    input  logic [DATA_WIDTH-1:0]   hr_data,
    output logic                    busy
);

    localparam int MASK_W     = DATA_WIDTH / 8;
    localparam int STEP       = DATA_WIDTH / 8;
    localparam int ALIGN_BITS = $clog2(STEP);
    localparam logic [ADDR_WIDTH-1:0] STEP_A = ADDR_WIDTH'(STEP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_RDATA,
        S_RESP
    } state_t;

    state_t                  state_q;
    logic [23:0]             hdr_q;
    logic                    err_q;
    logic [ADDR_WIDTH-1:0]   cur_addr_q;
    logic [7:0]              remaining_q;
    logic                    out_valid_q;
    logic [DATA_WIDTH-1:0]   out_bits_q;

    logic                    cmd_write;
    logic                    cmd_read;
    logic                    cmd_reserved;
    logic [7:0]              hdr_len;
    logic                    addr_misaligned;
    logic                    out_load;
    logic [DATA_WIDTH-1:0]   status_word;

    assign cmd_write       = (hdr_q[1:0] == 2'd1);
    assign cmd_read        = (hdr_q[1:0] == 2'd2);
    assign cmd_reserved    = !(cmd_write || cmd_read);
    assign hdr_len         = hdr_q[23:16];
    // The address word is checked as it arrives, so alignment is taken from in_bits.
    assign addr_misaligned = |in_bits[ALIGN_BITS-1:0];
    // The output register can take a new word when it is empty or being drained this cycle.
    assign out_load        = !out_valid_q || out_ready;
    assign status_word     = DATA_WIDTH'({err_q, 7'b0, hdr_q});

    assign in_ready  = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_WDATA);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign out_bits  = out_bits_q;
    // A bad write still consumes its data words, but the write strobe stays low.
    assign hw_en     = (state_q == S_WDATA) && in_valid && !err_q;
    assign hw_addr   = cur_addr_q;
    assign hw_data   = in_bits;
    assign hw_mask   = hdr_q[8 +: MASK_W];
    assign hr_addr   = cur_addr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            hdr_q       <= '0;
            err_q       <= 1'b0;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            out_valid_q <= 1'b0;
            out_bits_q  <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every read in this block sees
            // pre-edge values; a later load below overrides this drain.
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        hdr_q   <= in_bits[23:0];
                        state_q <= S_ADDR;
                    end
                end

                S_ADDR: begin
                    if (in_valid) begin
                        cur_addr_q  <= in_bits[ADDR_WIDTH-1:0];
                        remaining_q <= hdr_len;
                        err_q       <= cmd_reserved || addr_misaligned;
                        // A bad read moves no data. A bad write still drains its words.
                        if (cmd_reserved || (hdr_len == 8'd0) || (cmd_read && addr_misaligned)) begin
                            state_q <= S_RESP;
                        end else if (cmd_write) begin
                            state_q <= S_WDATA;
                        end else begin
                            state_q <= S_RDATA;
                        end
                    end
                end

                S_WDATA: begin
                    if (in_valid) begin
                        cur_addr_q  <= cur_addr_q + STEP_A;
                        remaining_q <= remaining_q - 8'd1;
                        if (remaining_q == 8'd1) begin
                            state_q <= S_RESP;
                        end
                    end
                end

                S_RDATA: begin
                    if (out_load) begin
                        out_bits_q  <= hr_data;
                        out_valid_q <= 1'b1;
                        cur_addr_q  <= cur_addr_q + STEP_A;
                        remaining_q <= remaining_q - 8'd1;
                        if (remaining_q == 8'd1) begin
                            state_q <= S_RESP;
                        end
                    end
                end

                S_RESP: begin
                    if (out_load) begin
                        out_bits_q  <= status_word;
                        out_valid_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_htif_mem_bridge.sv
module tb_htif_mem_bridge;

    localparam int AW = 21;
    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_bits;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_bits;
    logic [AW-1:0] hw_addr;
    logic [DW-1:0] hw_data;
    logic [3:0]    hw_mask;
    logic          hw_en;
    logic [AW-1:0] hr_addr;
    logic [DW-1:0] hr_data;
    logic          busy;

    htif_mem_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bits   (in_bits),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits),
        .hw_addr   (hw_addr),
        .hw_data   (hw_data),
        .hw_mask   (hw_mask),
        .hw_en     (hw_en),
        .hr_addr   (hr_addr),
        .hr_data   (hr_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scratchpad memory: word array indexed by byte address / 4.
    logic [31:0] mem [0:(1<<19)-1];
    assign hr_data = mem[hr_addr[AW-1:2]];

    always @(posedge clk) begin
        if (hw_en) begin
            for (int b = 0; b < 4; b++) begin
                if (hw_mask[b]) mem[hw_addr[AW-1:2]][8*b +: 8] <= hw_data[8*b +: 8];
            end
        end
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    mask;
    } wr_t;

    wr_t         exp_w[$];
    logic [31:0] exp_o[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    logic        held_valid = 1'b0;
    logic [31:0] held_bits  = '0;

    always @(negedge clk) begin
        if (reset) begin
            held_valid = 1'b0;
        end else begin
            if (hw_en) begin
                if (exp_w.size() == 0) begin
                    check("write_unexpected", hw_en, 0);
                end else begin
                    wr_t e;
                    e = exp_w.pop_front();
                    check("hw_addr", hw_addr, e.addr);
                    check("hw_data", hw_data, e.data);
                    check("hw_mask", hw_mask, e.mask);
                end
            end
            if (held_valid) begin
                check("stall_valid", out_valid, 1);
                check("stall_bits", out_bits, held_bits);
            end
            if (out_valid && out_ready) begin
                if (exp_o.size() == 0) check("out_unexpected", out_valid, 0);
                else                   check("out_bits", out_bits, exp_o.pop_front());
            end
            held_valid = out_valid && !out_ready;
            held_bits  = out_bits;
        end
    end

    // out_ready driver: always-ready, or toggling every cycle to create stalls.
    logic toggle_mode = 1'b0;
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = toggle_mode ? ~out_ready : 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_word(input logic [31:0] w);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_bits  = w;
        while (!in_ready && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("in_ready_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while ((exp_o.size() != 0 || busy || out_valid) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, busy || out_valid || (exp_o.size() != 0), 0);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_bits  = '0;
        mem[32'h108 >> 2]    = 32'h0BADF00D;
        mem[32'h1FFFFC >> 2] = 32'h11112222;
        mem[0]               = 32'h33334444;
        mem[32'h300 >> 2]    = 32'hFFFFFFFF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_bits", out_bits, 0);
        check("rst_hw_en", hw_en, 0);
        reset = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_hr_addr", hr_addr, 0);
        @(posedge clk);
        #1;

        // Test 1: two-word write
        exp_w.push_back('{addr: 21'h100, data: 32'hDEADBEEF, mask: 4'hF});
        exp_w.push_back('{addr: 21'h104, data: 32'h12345678, mask: 4'hF});
        exp_o.push_back(32'h00020F01);
        send_word(32'h00020F01);
        send_word(32'h00000100);
        send_word(32'hDEADBEEF);
        send_word(32'h12345678);
        wait_done("t1_done");

        // Test 2: three-word read with output stalls
        exp_o.push_back(32'hDEADBEEF);
        exp_o.push_back(32'h12345678);
        exp_o.push_back(32'h0BADF00D);
        exp_o.push_back(32'h00030002);
        toggle_mode = 1'b1;
        send_word(32'h00030002);
        send_word(32'h00000100);
        wait_done("t2_done");
        toggle_mode = 1'b0;
        @(posedge clk);
        #1;

        // Test 3: misaligned write consumes its data but never writes
        exp_o.push_back(32'h80010F01);
        send_word(32'h00010F01);
        send_word(32'h00000102);
        send_word(32'hAAAA5555);
        wait_done("t3_done");
        check("t3_mem_kept", mem[32'h100 >> 2], 32'hDEADBEEF);

        // Test 4: reserved command, then zero-length read and write
        exp_o.push_back(32'h80050003);
        send_word(32'h00050003);
        send_word(32'h00000000);
        wait_done("t4a_done");
        exp_o.push_back(32'h00000F02);
        send_word(32'h00000F02);
        send_word(32'h00000200);
        wait_done("t4b_done");
        exp_o.push_back(32'h00000F01);
        send_word(32'h00000F01);
        send_word(32'h00000200);
        wait_done("t4c_done");

        // Test 5: read across the top of the address space, then a partial-mask write
        exp_o.push_back(32'h11112222);
        exp_o.push_back(32'h33334444);
        exp_o.push_back(32'h00020002);
        send_word(32'h00020002);
        send_word(32'h001FFFFC);
        wait_done("t5a_done");
        exp_w.push_back('{addr: 21'h300, data: 32'h0000ABCD, mask: 4'h3});
        exp_o.push_back(32'h00010301);
        send_word(32'h00010301);
        send_word(32'h00000300);
        send_word(32'h0000ABCD);
        wait_done("t5b_done");
        check("t5_mem_masked", mem[32'h300 >> 2], 32'hFFFFABCD);

        // Test 6: reset during a write burst, then a clean write
        exp_w.push_back('{addr: 21'h400, data: 32'h55AA55AA, mask: 4'hF});
        send_word(32'h00030F01);
        send_word(32'h00000400);
        send_word(32'h55AA55AA);
        in_valid = 1'b1;
        in_bits  = 32'h66666666;
        reset    = 1'b1;
        #1;
        check("t6_hw_en_rst", hw_en, 0);
        check("t6_out_valid_rst", out_valid, 0);
        check("t6_busy_rst", busy, 0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("t6_in_ready", in_ready, 1);
        check("t6_mem_kept", mem[32'h400 >> 2], 32'h55AA55AA);
        exp_w.push_back('{addr: 21'h500, data: 32'h77778888, mask: 4'hF});
        exp_o.push_back(32'h00010F01);
        send_word(32'h00010F01);
        send_word(32'h00000500);
        send_word(32'h77778888);
        wait_done("t6_done");
        check("t6_mem_new", mem[32'h500 >> 2], 32'h77778888);

        repeat (3) @(posedge clk);
        #1;
        check("writes_left", exp_w.size(), 0);
        check("outs_left", exp_o.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
